fft_mag_wr: RTL and testbench

FFT_MAG_WR -- requirements
Module: fft_mag_wr

---
 rtl/fft_mag_wr_pkg.sv | 12 +
 rtl/fft_mag_wr_mag.sv | 54 +++++
 rtl/fft_mag_wr.sv | 128 ++++++++++++
 tb/tb_fft_mag_wr.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/fft_mag_wr_pkg.sv
// Shared types and constants for the FFT magnitude writer: FSM encoding,
// default geometry and the shift amounts of the alpha-max/beta-min estimate.
package fft_mag_wr_pkg;
  typedef enum logic [2:0] {S_IDLE, S_ARM, S_CAP, S_FLUSH, S_DONE} state_t;

  localparam int FFT_LEN_DEF = 4096;
  localparam int DATA_W_DEF  = 16;
  localparam int ADDR_W_DEF  = 12;
  localparam int DC_BINS_DEF = 4;
  localparam int MAG_SH_A    = 2;
  localparam int MAG_SH_B    = 3;
endpackage

// File: rtl/fft_mag_wr_mag.sv
// Magnitude estimate max + min/4 + min/8, saturated; 2-cycle pipeline
// carrying the bin address; no backpressure (one result per valid input).
module mag_approx
  import fft_mag_wr_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_vld,
  input  logic [DATA_W-1:0] i_re,
  input  logic [DATA_W-1:0] i_im,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              o_vld,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_dat
);
  logic [DATA_W:0]   w_ext_re, w_ext_im, w_abs_re, w_abs_im;
  logic [DATA_W:0]   r_mx, r_mn;
  logic [ADDR_W-1:0] r_addr1;
  logic              r_vld1;
  logic [DATA_W+1:0] w_sum;
  logic [DATA_W-1:0] w_sat;

  // One extra bit so that the most negative input negates exactly.
  assign w_ext_re = {i_re[DATA_W-1], i_re};
  assign w_ext_im = {i_im[DATA_W-1], i_im};
  assign w_abs_re = w_ext_re[DATA_W] ? (~w_ext_re + 1'b1) : w_ext_re;
  assign w_abs_im = w_ext_im[DATA_W] ? (~w_ext_im + 1'b1) : w_ext_im;

  assign w_sum = {1'b0, r_mx} + {1'b0, r_mn >> MAG_SH_A} + {1'b0, r_mn >> MAG_SH_B};
  assign w_sat = (|w_sum[DATA_W+1:DATA_W]) ? {DATA_W{1'b1}} : w_sum[DATA_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld1  <= 1'b0;
      r_mx    <= '0;
      r_mn    <= '0;
      r_addr1 <= '0;
      o_vld   <= 1'b0;
      o_addr  <= '0;
      o_dat   <= '0;
    end else begin
      r_vld1  <= i_vld;
      r_addr1 <= i_addr;
      r_mx    <= (w_abs_re > w_abs_im) ? w_abs_re : w_abs_im;
      r_mn    <= (w_abs_re > w_abs_im) ? w_abs_im : w_abs_re;
      o_vld   <= r_vld1;
      o_addr  <= r_addr1;
      o_dat   <= w_sat;
    end
  end
endmodule

// File: rtl/fft_mag_wr.sv
// Captures one FFT frame on start and writes bins 0..FFT_LEN/2-1 of magnitude to RAM,
// 2-cycle write latency, no backpressure; FFT_MAG_DC_BLANK_EN zeroes the first DC_BINS bins.
module fft_mag_wr
  import fft_mag_wr_pkg::*;
#(
  parameter int FFT_LEN = FFT_LEN_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DC_BINS = DC_BINS_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] fft_re,
  input  logic [DATA_W-1:0] fft_im,
  input  logic              fft_valid,
  input  logic              fft_last,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              done,
  output logic              busy,
  output logic              frame_err
);
  localparam int CNT_W = $clog2(FFT_LEN);
  localparam logic [CNT_W-1:0] LAST_BIN = CNT_W'(FFT_LEN - 1);
  localparam logic [CNT_W-1:0] HALF_BIN = CNT_W'(FFT_LEN / 2);
  localparam logic [CNT_W-1:0] DC_LIM   = CNT_W'(DC_BINS);
`ifdef FFT_MAG_DC_BLANK_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_bin;
  logic             r_first, r_sync, r_err;
  logic             w_first_nxt, w_sync_nxt, w_err_nxt;
  logic             w_take, w_wr, w_blank;
  logic [DATA_W-1:0] w_re, w_im;

  // r_sync: a boundary was consumed by an errored beat, so the next beat is bin 0.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_sync_nxt  = r_sync;
    w_err_nxt   = r_err;
    w_first_nxt = r_first & ~(fft_valid & fft_last);
    w_take      = 1'b0;
    w_bin       = r_cnt;
    case (r_state)
      S_IDLE: if (start) begin
        w_state_nxt = S_ARM;
        w_err_nxt   = 1'b0;
        w_sync_nxt  = 1'b0;
      end
      S_ARM: if (fft_valid) begin
        if (r_sync || (r_first && !fft_last)) begin
          w_take = 1'b1;
          w_bin  = '0;
        end else if (fft_last) begin
          w_state_nxt = S_CAP;
          w_cnt_nxt   = '0;
        end
      end
      S_CAP:   w_take = fft_valid;
      S_FLUSH: begin
        if (r_cnt == CNT_W'(1)) w_state_nxt = S_DONE;
        else                    w_cnt_nxt   = r_cnt + 1'b1;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase

    if (w_take) begin
      if (w_bin == LAST_BIN && fft_last) begin
        w_state_nxt = S_FLUSH;
        w_cnt_nxt   = '0;
        w_sync_nxt  = 1'b0;
      end else if (w_bin == LAST_BIN || fft_last) begin
        w_state_nxt = S_ARM;
        w_err_nxt   = 1'b1;
        w_sync_nxt  = fft_last;
      end else begin
        w_state_nxt = S_CAP;
        w_cnt_nxt   = w_bin + 1'b1;
        w_sync_nxt  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_first <= 1'b1;
      r_sync  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_first <= w_first_nxt;
      r_sync  <= w_sync_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign w_wr    = w_take && (w_bin < HALF_BIN);
  assign w_blank = BLANK_EN && (w_bin < DC_LIM);
  assign w_re    = w_blank ? '0 : fft_re;
  assign w_im    = w_blank ? '0 : fft_im;

  mag_approx #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_mag (
    .clk    (clk),
    .rst    (rst),
    .i_vld  (w_wr),
    .i_re   (w_re),
    .i_im   (w_im),
    .i_addr (ADDR_W'(w_bin)),
    .o_vld  (wr_en),
    .o_addr (wr_addr),
    .o_dat  (wr_data)
  );

  assign done      = (r_state == S_DONE);
  assign busy      = (r_state == S_ARM) || (r_state == S_CAP) || (r_state == S_FLUSH);
  assign frame_err = r_err;
endmodule

// File: tb/tb_fft_mag_wr.sv
// Bench for fft_mag_wr at FFT_LEN=16: table vectors plus scoreboarded frame sequences.
module tb_fft_mag_wr;
`ifdef FFT_MAG_DC_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, start, fft_valid, fft_last;
  logic [15:0] fft_re, fft_im;
  logic        wr_en, done, busy, frame_err;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;

  typedef struct { int addr; int data; int cyc; } exp_t;
  typedef struct { int re; int im; int mag; } vec_t;

  exp_t sb[$];
  vec_t tbl[8];
  int   tests = 0, fails = 0, cyc = 0;
  int   done_cnt = 0, done_cyc = -100, last_cyc = 0;

  fft_mag_wr #(.FFT_LEN(16), .DATA_W(16), .ADDR_W(4), .DC_BINS(4)) dut (
    .clk(clk), .rst(rst), .start(start), .fft_re(fft_re), .fft_im(fft_im),
    .fft_valid(fft_valid), .fft_last(fft_last), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .done(done), .busy(busy), .frame_err(frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int model(input int re, input int im, input int bin);
    int a, b, mx, mn, m;
    a  = (re < 0) ? -re : re;
    b  = (im < 0) ? -im : im;
    mx = (a > b) ? a : b;
    mn = (a > b) ? b : a;
    m  = mx + mn / 4 + mn / 8;
    if (m > 65535) m = 65535;
    if (BLANK && bin < 4) m = 0;
    return m;
  endfunction

  // Scoreboard: every write must match the oldest expectation, including its cycle.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      if (sb.size() == 0) chk("unexpected_write_addr", 32'(wr_addr), 32'hFFFF_FFFF);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("wr_addr", 32'(wr_addr), e.addr);
        chk("wr_data", 32'(wr_data), e.data);
        chk("wr_cycle", cyc, e.cyc);
      end
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic drive(input logic v, input int re, input int im, input logic l,
                       input logic st, input int bin, input int ex);
    @(posedge clk); #1;
    fft_valid = v; fft_re = 16'(re); fft_im = 16'(im); fft_last = l; start = st;
    if (v && l) last_cyc = cyc;
    if (ex >= 0) sb.push_back('{bin, ex, cyc + 2});
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 0, 0, 1'b0, 1'b0, -1, -1);
  endtask

  task automatic frame(input int nb, input int last_at, input int gap, input logic ex, input int st_at);
    for (int k = 0; k < nb; k++) begin
      if (gap > 0) idle($urandom_range(0, gap));
      drive(1'b1, 100 * k, -50 * k, k == last_at, k == st_at, k,
            (ex && k < 8) ? model(100 * k, -50 * k, k) : -1);
    end
  endtask

  task automatic arm_and_sync();
    drive(1'b0, 0, 0, 1'b0, 1'b1, -1, -1);
    idle(1);
    drive(1'b1, 7, 7, 1'b1, 1'b0, -1, -1);
  endtask

  task automatic wait_done(input string nm, input int base);
    int n = 0;
    while (done_cnt == base && n < 16) begin @(negedge clk); #1; n++; end
    chk({nm, "_done_count"}, done_cnt - base, 1);
    chk({nm, "_done_latency"}, done_cyc - last_cyc, 3);
    chk({nm, "_sb_empty"}, sb.size(), 0);
  endtask

  initial begin
    int base, f2_last;
    tbl[0] = '{1000, 1000, 1375};   tbl[1] = '{-7, 3, 7};
    tbl[2] = '{8, -16, 19};         tbl[3] = '{0, 0, 0};
    tbl[4] = '{-32768, -32768, 45056}; tbl[5] = '{32767, 0, 32767};
    tbl[6] = '{0, -32768, 32768};   tbl[7] = '{-32768, 32767, 45054};

    rst = 1'b1; start = 1'b0; fft_valid = 1'b0; fft_last = 1'b0; fft_re = '0; fft_im = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_wr_en", 32'(wr_en), 0);   chk("rst_wr_addr", 32'(wr_addr), 0);
    chk("rst_wr_data", 32'(wr_data), 0); chk("rst_done", 32'(done), 0);
    chk("rst_busy", 32'(busy), 0);     chk("rst_frame_err", 32'(frame_err), 0);
    @(posedge clk); #1 rst = 1'b0;

    // First frame after reset: first valid beat is bin 0.
    base = done_cnt;
    drive(1'b0, 0, 0, 1'b0, 1'b1, -1, -1);
    idle(1);
    @(negedge clk); chk("a_busy", 32'(busy), 1);
    frame(16, 15, 0, 1'b1, -1);
    idle(1);
    wait_done("a", base);
    chk("a_frame_err", 32'(frame_err), 0);
    chk("a_busy_after", 32'(busy), 0);

    // Table vectors in bins 0..7, including the most negative corner.
    base = done_cnt;
    arm_and_sync();
    for (int i = 0; i < 16; i++)
      drive(1'b1, (i < 8) ? tbl[i].re : 0, (i < 8) ? tbl[i].im : 0, i == 15, 1'b0, i,
            (i < 8) ? ((BLANK && i < 4) ? 0 : tbl[i].mag) : -1);
    idle(1);
    wait_done("tbl", base);

    // Random valid gaps.
    base = done_cnt;
    arm_and_sync();
    frame(16, 15, 3, 1'b1, -1);
    idle(1);
    wait_done("gap", base);

    // Early fft_last at beat 10, then recapture of the following frame.
    base = done_cnt;
    arm_and_sync();
    frame(10, 9, 0, 1'b1, -1);
    idle(1);
    @(negedge clk); chk("err_set", 32'(frame_err), 1);
    chk("err_busy", 32'(busy), 1);
    frame(16, 15, 0, 1'b1, -1);
    idle(1);
    wait_done("err", base);
    chk("err_sticky", 32'(frame_err), 1);
    drive(1'b0, 0, 0, 1'b0, 1'b1, -1, -1);
    idle(1);
    @(negedge clk); chk("err_cleared", 32'(frame_err), 0);

    // Reset at beat 5 of a capture (machine is already armed).
    base = done_cnt;
    drive(1'b1, 7, 7, 1'b1, 1'b0, -1, -1);
    for (int k = 0; k < 5; k++)
      drive(1'b1, 100 * k, -50 * k, 1'b0, 1'b0, k, (k <= 3) ? model(100 * k, -50 * k, k) : -1);
    drive(1'b1, 500, -250, 1'b0, 1'b0, -1, -1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_wr_en", 32'(wr_en), 0); chk("mrst_wr_data", 32'(wr_data), 0);
    chk("mrst_wr_addr", 32'(wr_addr), 0); chk("mrst_busy", 32'(busy), 0);
    idle(10);
    chk("mrst_no_done", done_cnt - base, 0);
    chk("mrst_sb_empty", sb.size(), 0);
    drive(1'b0, 0, 0, 1'b0, 1'b1, -1, -1);
    idle(1);
    frame(16, 15, 0, 1'b1, -1);
    idle(1);
    wait_done("mrst_recap", base);

    // Start mid-stream waits for the boundary; start while busy or during done is ignored.
    base = done_cnt;
    idle(2);
    for (int k = 6; k < 16; k++)
      drive(1'b1, 100 * k, -50 * k, k == 15, k == 6, -1, -1);
    frame(16, 15, 0, 1'b1, 3);
    f2_last = last_cyc;
    for (int k = 0; k < 16; k++)
      drive(1'b1, 100 * k, -50 * k, k == 15, k == 2, -1, -1);
    idle(3);
    chk("mid_done_count", done_cnt - base, 1);
    chk("mid_done_latency", done_cyc - f2_last, 3);
    chk("mid_busy_after", 32'(busy), 0);
    chk("mid_sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
